// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op-code and FSM state types for alu_seq
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_MULT = 3'b010,
        OP_AND  = 3'b011,
        OP_OR   = 3'b100,
        OP_XOR  = 3'b101
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_MULT = 2'b10,
        ST_DONE = 2'b11
    } state_e;

endpackage

// File: rtl/seq_mult.sv
// rtl/seq_mult.sv - iterative signed shift-add multiplier, one partial product per cycle
module seq_mult #(
    parameter int W = 4
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic                    start_in,
    input  logic signed [W-1:0]     a_in,
    input  logic signed [W-1:0]     b_in,
    output logic                    done_out,
    output logic signed [2*W-1:0]   product_out
);

    localparam int CW = (W > 2) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    logic            busy_q, busy_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2*W-1:0]  mcand_q, mcand_d;
    logic [W-1:0]    mplier_q, mplier_d;
    logic [2*W-1:0]  acc_q, acc_d;
    logic [2*W-1:0]  pp;
    logic [2*W-1:0]  acc_next;
    logic            last;

    // The MSB of a two's complement multiplier has negative weight.
    assign last        = (cnt_q == LAST);
    assign pp          = mplier_q[0] ? mcand_q : '0;
    assign acc_next    = last ? (acc_q - pp) : (acc_q + pp);
    assign done_out    = busy_q & last;
    assign product_out = acc_next;

    always_comb begin
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        if (start_in) begin
            busy_d   = 1'b1;
            cnt_d    = '0;
            mcand_d  = {{W{a_in[W-1]}}, a_in};
            mplier_d = b_in;
            acc_d    = '0;
        end else if (busy_q) begin
            acc_d    = acc_next;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (last) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequential ALU with valid/ready request and response handshakes
module alu_seq
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 4
) (
    input  logic                             clk_in,
    input  logic                             rst_n_in,
    input  logic                             req_valid_in,
    output logic                             req_ready_out,
    input  logic [2:0]                       sel_in,
    input  logic signed [DATA_WIDTH-1:0]     a_in,
    input  logic signed [DATA_WIDTH-1:0]     b_in,
    output logic                             rsp_valid_out,
    input  logic                             rsp_ready_in,
    output logic signed [2*DATA_WIDTH-1:0]   result_out,
    output logic                             err_out
);

    localparam int W = DATA_WIDTH;

    state_e              state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic [W-1:0]        a_q, a_d;
    logic [W-1:0]        b_q, b_d;
    logic [2*W-1:0]      result_q, result_d;
    logic                err_q, err_d;

    logic                handshake;
    logic                mult_start;
    logic                mult_done;
    logic signed [2*W-1:0] mult_product;
    logic [2*W-1:0]      a_ext, b_ext;
    logic [W-1:0]        and_v, or_v, xor_v;

    assign req_ready_out = (state_q == ST_IDLE);
    assign rsp_valid_out = (state_q == ST_DONE);
    assign result_out    = result_q;
    assign err_out       = err_q;

    assign handshake  = req_valid_in & req_ready_out;
    assign mult_start = handshake & (sel_in == OP_MULT);

    assign a_ext = {{W{a_q[W-1]}}, a_q};
    assign b_ext = {{W{b_q[W-1]}}, b_q};
    assign and_v = a_q & b_q;
    assign or_v  = a_q | b_q;
    assign xor_v = a_q ^ b_q;

    // Operands go straight in at the handshake so the product lands after W cycles in MULT.
    seq_mult #(.W(W)) u_seq_mult (
        .clk_in      (clk_in),
        .rst_n_in    (rst_n_in),
        .start_in    (mult_start),
        .a_in        (a_in),
        .b_in        (b_in),
        .done_out    (mult_done),
        .product_out (mult_product)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                if (handshake) begin
                    op_d    = sel_in;
                    a_d     = a_in;
                    b_d     = b_in;
                    state_d = (sel_in == OP_MULT) ? ST_MULT : ST_EXEC;
                end
            end
            ST_EXEC: begin
                err_d   = 1'b0;
                state_d = ST_DONE;
                case (op_q)
                    OP_ADD:  result_d = a_ext + b_ext;
                    OP_SUB:  result_d = a_ext - b_ext;
                    OP_AND:  result_d = {{W{and_v[W-1]}}, and_v};
                    OP_OR:   result_d = {{W{or_v[W-1]}}, or_v};
                    OP_XOR:  result_d = {{W{xor_v[W-1]}}, xor_v};
                    default: begin
                        result_d = '0;
                        err_d    = 1'b1;
                    end
                endcase
            end
            ST_MULT: begin
                if (mult_done) begin
                    result_d = mult_product;
                    err_d    = 1'b0;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                if (rsp_ready_in) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter: DATA_WIDTH, default 4, operand width in bits (>=2).
REQ-002 clk_in  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n_in  input  1  reset, asynchronous assert, active-low.
REQ-004 req_valid_in  input  1  request present.
REQ-005 req_ready_out  output  1  block can accept a request.
REQ-006 sel_in  input  3  op-code: 000 ADD, 001 SUB, 010 MULT, 011 AND, 100 OR, 101 XOR; 110/111 illegal.
REQ-007 a_in  input  DATA_WIDTH signed  operand A.
REQ-008 b_in  input  DATA_WIDTH signed  operand B.
REQ-009 rsp_valid_out  output  1  result available.
REQ-010 rsp_ready_in  input  1  consumer takes result.
REQ-011 result_out  output  2*DATA_WIDTH signed  registered result.
REQ-012 err_out  output  1  illegal op-code flag, qualified by rsp_valid_out.

Function
REQ-013 FSM states SHALL be IDLE, EXEC, MULT, DONE.
REQ-014 req_ready_out SHALL be 1 only in IDLE; handshake = req_valid_in & req_ready_out at a rising edge.
REQ-015 On handshake, sel_in/a_in/b_in SHALL be captured into internal registers; later input changes SHALL not affect the operation.
REQ-016 IDLE -> MULT on handshake with op 010; IDLE -> EXEC on any other op; IDLE held otherwise.
REQ-017 EXEC SHALL last exactly one cycle, register result_out/err_out, then go to DONE.
REQ-018 ADD/SUB SHALL sign-extend both operands to 2*DATA_WIDTH before the operation; no overflow possible.
REQ-019 AND/OR/XOR SHALL operate on DATA_WIDTH bits, result sign-extended to 2*DATA_WIDTH.
REQ-020 MULT SHALL produce the full signed 2*DATA_WIDTH product, iterating one partial product per cycle for exactly DATA_WIDTH cycles in MULT, then go to DONE.
REQ-021 Illegal op-code SHALL yield result_out = 0 and err_out = 1 via EXEC; err_out = 0 for all legal ops.
REQ-022 Latency: handshake at edge k -> rsp_valid_out high after edge k+1 (non-MULT) or edge k+DATA_WIDTH (MULT).
REQ-023 rsp_valid_out SHALL be 1 exactly in DONE; result_out/err_out SHALL stay stable while rsp_valid_out & !rsp_ready_in.
REQ-024 DONE -> IDLE when rsp_ready_in is 1 at an edge; no new request accepted in that same edge (req_ready_out low in DONE).
REQ-025 rsp_ready_in SHALL be ignored outside DONE; req_valid_in ignored outside IDLE.
REQ-026 result_out/err_out SHALL retain the last value after leaving DONE until overwritten by the next operation.

Reset
REQ-027 rst_n_in low SHALL immediately force state IDLE, result_out = 0, err_out = 0, rsp_valid_out = 0, req_ready_out = 1 (after reset released), multiplier iteration state cleared.
REQ-028 Reset during EXEC/MULT/DONE SHALL abandon the operation with no response issued.

Structure
REQ-029 Op-code enum (3-bit) and FSM state enum SHALL live in shared package alu_pkg.
REQ-030 Iterative signed multiplier SHALL be a sub-module seq_mult (start, operands, done, product), clocked by clk_in and reset by rst_n_in.

Verification (DATA_WIDTH = 4)
REQ-031 ADD a=7, b=7 -> after 2 edges rsp_valid_out=1, result_out=8'h0E, err_out=0.
REQ-032 SUB a=-8, b=7 -> result_out=8'hF1 (-15), err_out=0.
REQ-033 MULT a=-8, b=-8 -> rsp_valid_out high exactly 4 edges after handshake, result_out=8'h40; MULT a=-3, b=5 -> 8'hF1.
REQ-034 sel_in=3'b110, a=5, b=3 -> result_out=0, err_out=1, then IDLE after rsp_ready_in.
REQ-035 XOR a=4'b1010, b=4'b0110 with rsp_ready_in low 3 cycles -> result_out=8'hFC held stable, req_ready_out=0, req_valid_in pulses ignored; accept on rsp_ready_in=1.
REQ-036 rst_n_in low during MULT cycle 2 -> all outputs zero asynchronously, no rsp_valid_out afterwards, next ADD 1+1 returns 8'h02.
